clkctrl_sched: RTL and testbench

Sequencing controller for the PHI2-stopping clock switch. It owns the switch's `hsclk_sel` and `cpuclk_div_sel` inputs and arbitrates speed demand from three sources: a configuration turbo enable, a slow-access request from address decode, and a forced-low-speed hold. It confirms every transition against the switch's `hsclk_selected` / `lsclk_selected` status, which are resynchronised locally. It changes the divider only while low speed is confirmed, applies hysteresis before returning to high speed, and flags hung switchovers.

---
 rtl/clkctrl_sched.sv | 169 ++++++++++++++++
 tb/tb_clkctrl_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkctrl_sched.sv
// clkctrl_sched: sequencing controller for the PHI2-stopping clock switch.
// Drives the switch's speed request and divider code, resynchronises its
// status flags, confirms every speed change against them, holds off the
// return to high speed with an idle dwell, and flags hung switchovers.
module clkctrl_sched #(
    parameter int HOLD_LS     = 8,    // idle cycles before high speed is requested (1..255)
    parameter int TIMEOUT     = 64,   // cycles allowed for a switchover (2..1023)
    parameter int SYNC_STAGES = 2     // flop stages per status input (>=2)
) (
    input  logic       hsclk_in,
    input  logic       rst,
    input  logic       turbo_en,
    input  logic [1:0] div_cfg,
    input  logic       slow_req,
    input  logic       ls_hold,
    input  logic       err_clr,
    input  logic       hsclk_selected,
    input  logic       lsclk_selected,
    output logic       hsclk_sel,
    output logic [1:0] cpuclk_div_sel,
    output logic       ls_ready,
    output logic       hs_active,
    output logic       switch_err
);

    typedef enum logic [1:0] {
        LS_WAIT = 2'd0,   // low speed requested, waiting for the switch to confirm
        LS_RUN  = 2'd1,   // low speed confirmed; divider may change here only
        HS_WAIT = 2'd2,   // high speed requested, waiting for the switch to confirm
        HS_RUN  = 2'd3    // high speed confirmed
    } state_t;

    // Terminal counts of the dwell and switchover timers.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_LS - 1);
    localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);

    state_t                 state;
    logic [7:0]             hold;
    logic [9:0]             tmo;
    logic [SYNC_STAGES-1:0] hs_sync;
    logic [SYNC_STAGES-1:0] ls_sync;
    logic                   hs_s;
    logic                   ls_s;
    logic                   slow_dem;
    logic                   div_diff;
    logic                   ls_confirmed;
    logic                   hs_confirmed;

    // Resynchronise the asynchronous switch status flags into the hsclk domain.
    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            hs_sync <= '0;
            ls_sync <= '0;
        end else begin
            hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected};
            ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected};
        end
    end

    assign hs_s = hs_sync[SYNC_STAGES-1];
    assign ls_s = ls_sync[SYNC_STAGES-1];

    // Any demand source that must keep (or bring) the CPU at low speed.
    assign slow_dem = slow_req | ls_hold | ~turbo_en;

    // The configured divider differs from the one the switch is using.
    assign div_diff = (div_cfg != cpuclk_div_sel);

    // A speed is confirmed only when exactly one status flag is set; both
    // low is the PHI2-stopped gap during a switchover.
    assign ls_confirmed = ls_s & ~hs_s;
    assign hs_confirmed = hs_s & ~ls_s;

    // Speed sequencer with registered switch controls, status decodes and error flag.
    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            state          <= LS_WAIT;
            hsclk_sel      <= 1'b0;
            cpuclk_div_sel <= 2'b10;
            ls_ready       <= 1'b0;
            hs_active      <= 1'b0;
            switch_err     <= 1'b0;
            hold           <= '0;
            tmo            <= '0;
        end else begin
            // NOTE: later nonblocking assignments to the same register in this
            // block override earlier ones, so defaults and the error clear come
            // first and the state-specific updates (including error set) follow.
            ls_ready  <= 1'b0;
            hs_active <= 1'b0;
            if (err_clr) begin
                switch_err <= 1'b0;
            end

            unique case (state)
                LS_WAIT: begin
                    if (ls_confirmed) begin
                        state <= LS_RUN;
                        tmo   <= '0;
                        hold  <= '0;
                    end else if (tmo == TMO_LAST) begin
                        // Nothing to fall back to: flag it and keep waiting.
                        switch_err <= 1'b1;
                        tmo        <= '0;
                    end else begin
                        tmo <= tmo + 10'd1;
                    end
                end

                LS_RUN: begin
                    if (!ls_s || hs_s) begin
                        // Status glitched or switch moved on its own: re-confirm.
                        state <= LS_WAIT;
                    end else begin
                        ls_ready <= 1'b1;
                        if (div_diff) begin
                            cpuclk_div_sel <= div_cfg;
                            hold           <= '0;
                        end else if (slow_dem) begin
                            hold <= '0;
                        end else if (hold == HOLD_LAST) begin
                            state     <= HS_WAIT;
                            hsclk_sel <= 1'b1;
                            ls_ready  <= 1'b0;
                            hold      <= '0;
                            tmo       <= '0;
                        end else begin
                            hold <= hold + 8'd1;
                        end
                    end
                end

                HS_WAIT: begin
                    if (slow_dem || div_diff) begin
                        state     <= LS_WAIT;
                        hsclk_sel <= 1'b0;
                        tmo       <= '0;
                    end else if (hs_confirmed) begin
                        state <= HS_RUN;
                    end else if (tmo == TMO_LAST) begin
                        switch_err <= 1'b1;
                        state      <= LS_WAIT;
                        hsclk_sel  <= 1'b0;
                        tmo        <= '0;
                    end else begin
                        tmo <= tmo + 10'd1;
                    end
                end

                HS_RUN: begin
                    if (slow_dem || div_diff || !hs_s) begin
                        state     <= LS_WAIT;
                        hsclk_sel <= 1'b0;
                        tmo       <= '0;
                    end else begin
                        hs_active <= 1'b1;
                    end
                end

                default: begin
                    state     <= LS_WAIT;
                    hsclk_sel <= 1'b0;
                    tmo       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkctrl_sched.sv
// Testbench for clkctrl_sched: emulates the clock switch, predicts the
// controller's outputs from its sequencing rules every cycle, and pins the
// key latencies with hand-computed expectations.
module tb_clkctrl_sched;

    localparam int HOLD_LS     = 8;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;
    localparam int SW_DELAY    = 5;     // switch response time in cycles
    localparam int WAIT_LIMIT  = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       turbo_en = 1'b0;
    logic [1:0] div_cfg = 2'b00;
    logic       slow_req = 1'b0;
    logic       ls_hold = 1'b0;
    logic       err_clr = 1'b0;
    logic       hsclk_selected = 1'b0;
    logic       lsclk_selected = 1'b1;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       ls_ready;
    logic       hs_active;
    logic       switch_err;

    int total = 0;
    int bad   = 0;

    clkctrl_sched #(
        .HOLD_LS     (HOLD_LS),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .hsclk_in       (clk),
        .rst            (rst),
        .turbo_en       (turbo_en),
        .div_cfg        (div_cfg),
        .slow_req       (slow_req),
        .ls_hold        (ls_hold),
        .err_clr        (err_clr),
        .hsclk_selected (hsclk_selected),
        .lsclk_selected (lsclk_selected),
        .hsclk_sel      (hsclk_sel),
        .cpuclk_div_sel (cpuclk_div_sel),
        .ls_ready       (ls_ready),
        .hs_active      (hs_active),
        .switch_err     (switch_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Clock switch emulation: after the request changes, both status flags
    // drop (PHI2 stopped) and the new speed is reported SW_DELAY cycles on.
    // 'stuck' models a switch that never leaves low speed.
    // ---------------------------------------------------------------
    logic stuck = 1'b0;
    logic sw_hs = 1'b0;
    int   sw_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (stuck) begin
            hsclk_selected = 1'b0;
            lsclk_selected = 1'b1;
            sw_hs          = 1'b0;
            sw_cnt         = 0;
        end else if ((hsclk_sel === 1'b1) != sw_hs) begin
            if (sw_cnt == 0) begin
                hsclk_selected = 1'b0;
                lsclk_selected = 1'b0;
            end
            sw_cnt++;
            if (sw_cnt == SW_DELAY) begin
                sw_hs          = (hsclk_sel === 1'b1);
                hsclk_selected = sw_hs;
                lsclk_selected = !sw_hs;
                sw_cnt         = 0;
            end
        end else begin
            sw_cnt         = 0;
            hsclk_selected = sw_hs;
            lsclk_selected = !sw_hs;
        end
    end

    // ---------------------------------------------------------------
    // Reference model. Phases track what the switch is asked for and
    // whether it has been confirmed; 'age' is cycles spent in the phase,
    // 'idle' the run of demand-free cycles at confirmed low speed.
    // ---------------------------------------------------------------
    typedef enum int {PH_LS_PEND, PH_LS_OK, PH_HS_PEND, PH_HS_OK} phase_t;

    phase_t     ph = PH_LS_PEND;
    phase_t     nph;
    int         age = 0;
    int         idle = 0;
    logic [1:0] m_div = 2'b10;
    logic       m_err = 1'b0;
    logic       model_on = 1'b0;
    bit         hq[$];
    bit         lq[$];
    logic       dem, dd, hs_seen, ls_seen, err_evt;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            ph    = PH_LS_PEND;
            age   = 0;
            idle  = 0;
            m_div = 2'b10;
            m_err = 1'b0;
            hq.delete();
            lq.delete();
            for (int i = 0; i < SYNC_STAGES; i++) begin
                hq.push_back(1'b0);
                lq.push_back(1'b0);
            end
            model_on = 1'b1;
        end else if (model_on) begin
            dem     = slow_req | ls_hold | !turbo_en;
            dd      = (div_cfg != m_div);
            hs_seen = hq[0];
            ls_seen = lq[0];
            nph     = ph;
            err_evt = 1'b0;
            case (ph)
                PH_LS_PEND: begin
                    if (ls_seen && !hs_seen) nph = PH_LS_OK;
                    else if ((age % TIMEOUT) == TIMEOUT - 1) err_evt = 1'b1;
                end
                PH_LS_OK: begin
                    if (!ls_seen || hs_seen) nph = PH_LS_PEND;
                    else if (dd) begin
                        m_div = div_cfg;
                        idle  = 0;
                    end else if (dem) idle = 0;
                    else begin
                        idle++;
                        if (idle == HOLD_LS) nph = PH_HS_PEND;
                    end
                end
                PH_HS_PEND: begin
                    if (dem || dd) nph = PH_LS_PEND;
                    else if (hs_seen && !ls_seen) nph = PH_HS_OK;
                    else if (age == TIMEOUT - 1) begin
                        err_evt = 1'b1;
                        nph     = PH_LS_PEND;
                    end
                end
                PH_HS_OK: begin
                    if (dem || dd || !hs_seen) nph = PH_LS_PEND;
                end
            endcase
            if (err_evt) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (nph != ph) begin
                age = 0;
                if (nph == PH_LS_OK) idle = 0;
            end else if (age < 1000000) begin
                age++;
            end
            ph = nph;
            hq.push_back(hsclk_selected);
            void'(hq.pop_front());
            lq.push_back(lsclk_selected);
            void'(lq.pop_front());
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("cyc_hsclk_sel", hsclk_sel, (ph == PH_HS_PEND || ph == PH_HS_OK));
            check("cyc_div_sel", cpuclk_div_sel, m_div);
            check("cyc_ls_ready", ls_ready, (ph == PH_LS_OK && age > 0));
            check("cyc_hs_active", hs_active, (ph == PH_HS_OK && age > 0));
            check("cyc_switch_err", switch_err, m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_hs_sel(input logic v, input string nm);
        int i = 0;
        while (hsclk_sel !== v && i < WAIT_LIMIT) begin
            @(negedge clk);
            i++;
        end
        check(nm, hsclk_sel, v);
    endtask

    task automatic wait_ls_ready(input string nm);
        int i = 0;
        while (ls_ready !== 1'b1 && i < WAIT_LIMIT) begin
            @(negedge clk);
            i++;
        end
        check(nm, ls_ready, 1'b1);
    endtask

    task automatic wait_hs_active(input string nm);
        int i = 0;
        while (hs_active !== 1'b1 && i < WAIT_LIMIT) begin
            @(negedge clk);
            i++;
        end
        check(nm, hs_active, 1'b1);
    endtask

    logic [1:0] div_before;

    initial begin
        // Reset state, switch reporting low speed, turbo off.
        tick(3);
        check("rst_hsclk_sel", hsclk_sel, 1'b0);
        check("rst_div_sel", cpuclk_div_sel, 2'b10);
        check("rst_ls_ready", ls_ready, 1'b0);
        check("rst_hs_active", hs_active, 1'b0);
        check("rst_switch_err", switch_err, 1'b0);
        rst = 1'b0;
        // Two sync edges, one to enter LS_RUN, one for the ready decode.
        tick(3);
        check("boot_ls_ready_e3", ls_ready, 1'b0);
        check("boot_div_e3", cpuclk_div_sel, 2'b10);
        tick(1);
        check("boot_ls_ready_e4", ls_ready, 1'b1);
        check("boot_div_e4", cpuclk_div_sel, 2'b00);
        tick(30);
        check("no_turbo_hs_sel", hsclk_sel, 1'b0);

        // Turbo on: high speed requested after the full idle dwell.
        turbo_en = 1'b1;
        tick(HOLD_LS - 1);
        check("turbo_hs_sel_e7", hsclk_sel, 1'b0);
        tick(1);
        check("turbo_hs_sel_e8", hsclk_sel, 1'b1);
        check("turbo_ls_ready_wait", ls_ready, 1'b0);
        // Switch answers after 5 cycles, then 2 sync + 1 confirm + 1 decode.
        tick(7);
        check("turbo_hs_active_e15", hs_active, 1'b0);
        tick(1);
        check("turbo_hs_active_e16", hs_active, 1'b1);

        // Slow access in HS_RUN: request drops on the very next edge.
        slow_req = 1'b1;
        tick(1);
        check("slow_hs_sel_fall", hsclk_sel, 1'b0);
        check("slow_hs_active_fall", hs_active, 1'b0);
        slow_req = 1'b0;
        wait_ls_ready("slow_ls_ready_back");
        // Idle count is now 1; let it reach 5, then restart it with a pulse.
        tick(4);
        slow_req = 1'b1;
        tick(1);
        slow_req = 1'b0;
        tick(HOLD_LS - 1);
        check("restart_hs_sel_e7", hsclk_sel, 1'b0);
        tick(1);
        check("restart_hs_sel_e8", hsclk_sel, 1'b1);

        // Divider change while at high speed: back to low speed, load, dwell.
        wait_hs_active("div_reach_hs");
        div_cfg = 2'b10;
        tick(1);
        check("div_hs_sel_fall", hsclk_sel, 1'b0);
        div_before = cpuclk_div_sel;
        for (int i = 0; i < WAIT_LIMIT && ls_ready !== 1'b1; i++) begin
            div_before = cpuclk_div_sel;
            @(negedge clk);
        end
        check("div_ls_ready", ls_ready, 1'b1);
        check("div_before_ready", div_before, 2'b00);
        check("div_at_ready", cpuclk_div_sel, 2'b10);
        tick(HOLD_LS - 1);
        check("div_hs_sel_e7", hsclk_sel, 1'b0);
        tick(1);
        check("div_hs_sel_e8", hsclk_sel, 1'b1);

        // Switch stops answering: high-speed attempt times out.
        wait_hs_active("tmo_reach_hs");
        stuck = 1'b1;
        wait_hs_sel(1'b0, "tmo_fallback_ls");
        wait_hs_sel(1'b1, "tmo_retry_hs");
        tick(TIMEOUT - 1);
        check("tmo_hs_sel_c63", hsclk_sel, 1'b1);
        check("tmo_err_c63", switch_err, 1'b0);
        tick(1);
        check("tmo_err_c64", switch_err, 1'b1);
        check("tmo_hs_sel_c64", hsclk_sel, 1'b0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_cleared", switch_err, 1'b0);
        // Second timeout with a clear in the same cycle: set must win.
        wait_hs_sel(1'b1, "tmo2_retry_hs");
        tick(TIMEOUT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("tmo2_err_kept", switch_err, 1'b1);
        check("tmo2_hs_sel", hsclk_sel, 1'b0);

        // Recover, change divider, reach high speed, then reset.
        stuck   = 1'b0;
        div_cfg = 2'b01;
        wait_hs_active("rec_reach_hs");
        check("rec_div_sel", cpuclk_div_sel, 2'b01);
        rst = 1'b1;
        tick(1);
        check("mid_rst_hs_sel", hsclk_sel, 1'b0);
        check("mid_rst_hs_active", hs_active, 1'b0);
        check("mid_rst_div_sel", cpuclk_div_sel, 2'b10);
        check("mid_rst_err", switch_err, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
